// File: rtl/gpr_read_port.sv
// rtl/gpr_read_port.sv - GPR operand fetch with busy scoreboard; GPR_READ_BYPASS_EN enables writeback forwarding
module gpr_read_port #(
   parameter int SIZE = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [SIZE-1:0] r_in0,
   input  logic [SIZE-1:0] r_in1,
   input  logic [SIZE-1:0] r_in2,
   input  logic [SIZE-1:0] r_in3,
   input  logic [SIZE-1:0] r_in4,
   input  logic [SIZE-1:0] r_in5,
   input  logic [SIZE-1:0] r_in6,
   input  logic [SIZE-1:0] r_in7,
   input  logic [SIZE-1:0] wb_data,
   input  logic [2:0]      wb_sel,
   input  logic            wb_load,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      src_a,
   input  logic [2:0]      src_b,
   input  logic [2:0]      dst,
   input  logic            dst_en,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [SIZE-1:0] op_a,
   output logic [SIZE-1:0] op_b,
   output logic [7:0]      busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic            live_q;
   logic [2:0]      sa_q, sb_q;
   logic [1:0]      hazard_q, hazard_nxt;
   logic [7:0]      busy_q, busy_nxt;
   logic [SIZE-1:0] op_a_q, op_b_q, op_a_nxt, op_b_nxt;
   logic [SIZE-1:0] rd_a, rd_b;
   logic [7:0]      clr_vec, set_vec;
   logic            accept;
   logic            wb_hit_a, wb_hit_b;
`ifdef GPR_READ_BYPASS_EN
   logic [1:0]      hazard_left;
`endif

   // live_q keeps req_ready low until the first clock edge after reset release
   assign accept    = (state == S_IDLE) && live_q && req_valid;
   assign req_ready = (state == S_IDLE) && live_q;
   assign rsp_valid = (state == S_RESP);
   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign busy      = busy_q;

   assign wb_hit_a = wb_load && (wb_sel == sa_q);
   assign wb_hit_b = wb_load && (wb_sel == sb_q);

   // Register bank read mux for source A
   always_comb begin
      rd_a = r_in0;
      case (sa_q)
         3'd0: rd_a = r_in0;
         3'd1: rd_a = r_in1;
         3'd2: rd_a = r_in2;
         3'd3: rd_a = r_in3;
         3'd4: rd_a = r_in4;
         3'd5: rd_a = r_in5;
         3'd6: rd_a = r_in6;
         3'd7: rd_a = r_in7;
         default: rd_a = r_in0;
      endcase
   end

   // Register bank read mux for source B
   always_comb begin
      rd_b = r_in0;
      case (sb_q)
         3'd0: rd_b = r_in0;
         3'd1: rd_b = r_in1;
         3'd2: rd_b = r_in2;
         3'd3: rd_b = r_in3;
         3'd4: rd_b = r_in4;
         3'd5: rd_b = r_in5;
         3'd6: rd_b = r_in6;
         3'd7: rd_b = r_in7;
         default: rd_b = r_in0;
      endcase
   end

   // Scoreboard: writeback clears its register, an accepted dst sets it; set wins on a tie
   always_comb begin
      clr_vec  = wb_load ? (8'b1 << wb_sel) : 8'b0;
      set_vec  = (accept && dst_en) ? (8'b1 << dst) : 8'b0;
      busy_nxt = (busy_q & ~clr_vec) | set_vec;
   end

   // Next-state, hazard tracking and operand capture
   always_comb begin
      state_nxt  = state;
      hazard_nxt = hazard_q;
      op_a_nxt   = op_a_q;
      op_b_nxt   = op_b_q;
`ifdef GPR_READ_BYPASS_EN
      hazard_left = hazard_q & ~{wb_hit_b, wb_hit_a};
`endif
      case (state)
         S_IDLE: begin
            if (accept) begin
               // Sample busy before this request's dst lands, so src == dst never deadlocks;
               // a writeback retiring the source in this same cycle is not a hazard
               hazard_nxt = {busy_q[src_b] & ~clr_vec[src_b],
                             busy_q[src_a] & ~clr_vec[src_a]};
               state_nxt  = S_FETCH;
            end
         end
         S_FETCH: begin
`ifdef GPR_READ_BYPASS_EN
            if (hazard_left == 2'b00) begin
               // The bank updates on this edge, so a matching writeback carries the fresh value
               op_a_nxt  = wb_hit_a ? wb_data : rd_a;
               op_b_nxt  = wb_hit_b ? wb_data : rd_b;
               state_nxt = S_RESP;
            end else begin
               hazard_nxt = hazard_left;
            end
`else
            if (hazard_q == 2'b00) begin
               op_a_nxt  = rd_a;
               op_b_nxt  = rd_b;
               state_nxt = S_RESP;
            end else begin
               hazard_nxt = hazard_q & ~{wb_hit_b, wb_hit_a};
            end
`endif
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, capture and scoreboard registers; reset discards any request in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         live_q   <= 1'b0;
         sa_q     <= 3'd0;
         sb_q     <= 3'd0;
         hazard_q <= 2'b00;
         busy_q   <= 8'h00;
         op_a_q   <= '0;
         op_b_q   <= '0;
      end else begin
         state    <= state_nxt;
         live_q   <= 1'b1;
         if (accept) begin
            sa_q <= src_a;
            sb_q <= src_b;
         end
         hazard_q <= hazard_nxt;
         busy_q   <= busy_nxt;
         op_a_q   <= op_a_nxt;
         op_b_q   <= op_b_nxt;
      end
   end

endmodule

// File: tb/tb_gpr_read_port.sv
// tb/tb_gpr_read_port.sv - directed bench with a flag-based behavioural model of gpr_read_port
module tb_gpr_read_port;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] rf [8];
   logic        pre_we;
   logic [2:0]  pre_sel;
   logic [15:0] pre_data;
   logic [15:0] wb_data;
   logic [2:0]  wb_sel;
   logic        wb_load;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  src_a, src_b, dst;
   logic        dst_en;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] op_a, op_b;
   logic [7:0]  busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gpr_read_port #(.SIZE(16)) dut (
      .clk(clk), .reset(reset),
      .r_in0(rf[0]), .r_in1(rf[1]), .r_in2(rf[2]), .r_in3(rf[3]),
      .r_in4(rf[4]), .r_in5(rf[5]), .r_in6(rf[6]), .r_in7(rf[7]),
      .wb_data(wb_data), .wb_sel(wb_sel), .wb_load(wb_load),
      .req_valid(req_valid), .req_ready(req_ready),
      .src_a(src_a), .src_b(src_b), .dst(dst), .dst_en(dst_en),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .op_a(op_a), .op_b(op_b), .busy(busy)
   );

   // register bank: preload port for the bench, write port shared with the DUT snoop
   always @(posedge clk) begin
      if (pre_we) rf[pre_sel] <= pre_data;
      else if (wb_load) rf[wb_sel] <= wb_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // behavioural model: a request is pending until no source awaits a write, then a response is held
   bit          m_live, m_pend, m_rsp, m_need_a, m_need_b, acc, hit_a, hit_b;
   logic [7:0]  m_busy, clr, setv;
   logic [2:0]  m_sa, m_sb;
   logic [15:0] m_opa, m_opb;

   always @(posedge clk) begin
      if (!reset) begin
         m_live = 0; m_pend = 0; m_rsp = 0; m_need_a = 0; m_need_b = 0;
         m_busy = 8'h00; m_opa = 16'h0; m_opb = 16'h0; m_sa = 0; m_sb = 0;
      end else begin
         clr   = wb_load ? (8'h01 << wb_sel) : 8'h00;
         acc   = m_live && !m_pend && !m_rsp && req_valid;
         hit_a = wb_load && (wb_sel == m_sa);
         hit_b = wb_load && (wb_sel == m_sb);
         if (m_rsp) begin
            if (rsp_ready) m_rsp = 0;
         end else if (m_pend) begin
`ifdef GPR_READ_BYPASS_EN
            m_need_a = m_need_a && !hit_a;
            m_need_b = m_need_b && !hit_b;
            if (!m_need_a && !m_need_b) begin
               m_opa = hit_a ? wb_data : rf[m_sa];
               m_opb = hit_b ? wb_data : rf[m_sb];
               m_pend = 0; m_rsp = 1;
            end
`else
            if (!m_need_a && !m_need_b) begin
               m_opa = rf[m_sa];
               m_opb = rf[m_sb];
               m_pend = 0; m_rsp = 1;
            end else begin
               m_need_a = m_need_a && !hit_a;
               m_need_b = m_need_b && !hit_b;
            end
`endif
         end else if (acc) begin
            m_sa = src_a; m_sb = src_b;
            m_need_a = m_busy[src_a] && !clr[src_a];
            m_need_b = m_busy[src_b] && !clr[src_b];
            m_pend = 1;
         end
         setv   = (acc && dst_en) ? (8'h01 << dst) : 8'h00;
         m_busy = (m_busy & ~clr) | setv;
         m_live = 1;
      end
      #1;
      chk("m_busy", {24'd0, busy}, {24'd0, m_busy});
      chk("m_req_ready", {31'd0, req_ready}, {31'd0, (m_live && !m_pend && !m_rsp)});
      chk("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rsp});
      chk("m_op_a", {16'd0, op_a}, {16'd0, m_opa});
      chk("m_op_b", {16'd0, op_b}, {16'd0, m_opb});
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d, input logic de);
      int n = 0;
      while (!req_ready && n < 50) begin step(); n++; end
      if (!req_ready) begin
         errors++;
         $display("FAIL issue_timeout: req_ready got 0 expected 1");
      end
      req_valid = 1; src_a = a; src_b = b; dst = d; dst_en = de;
      step();
      req_valid = 0; dst_en = 0;
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 50) begin step(); n++; end
      if (!rsp_valid) begin
         errors++;
         $display("FAIL rsp_timeout: rsp_valid got 0 expected 1");
      end
   endtask

   task automatic consume();
      rsp_ready = 1;
      step();
      rsp_ready = 0;
   endtask

   task automatic txn(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d, input logic de);
      issue(a, b, d, de);
      wait_rsp();
      consume();
   endtask

   task automatic wb(input logic [2:0] s, input logic [15:0] v);
      wb_load = 1; wb_sel = s; wb_data = v;
      step();
      wb_load = 0;
   endtask

   logic [15:0] init_vals [8];

   initial begin
      #200000;
      $display("FAIL watchdog: time got limit expected finish");
      $fatal(1);
   end

   initial begin
      init_vals = '{16'hC0DE, 16'h0007, 16'h2222, 16'h1234, 16'h4444, 16'hABCD, 16'h6006, 16'h7777};
      reset = 0; pre_we = 0; pre_sel = 0; pre_data = 0;
      wb_load = 0; wb_sel = 0; wb_data = 0;
      req_valid = 0; src_a = 0; src_b = 0; dst = 0; dst_en = 0; rsp_ready = 0;
      step();
      for (int i = 0; i < 8; i++) begin
         pre_we = 1; pre_sel = 3'(i); pre_data = init_vals[i];
         step();
      end
      pre_we = 0;
      step();
      chk("rst_busy", {24'd0, busy}, 32'h00);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'h0);
      chk("rst_op_a", {16'd0, op_a}, 32'h0);
      chk("rst_op_b", {16'd0, op_b}, 32'h0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'h0);
      reset = 1;
      step();
      chk("rel_req_ready", {31'd0, req_ready}, 32'h1);

      // no hazard: response one edge after acceptance, held until taken
      issue(3'd3, 3'd5, 3'd0, 1'b0);
      chk("nohz_not_yet", {31'd0, rsp_valid}, 32'h0);
      step();
      chk("nohz_valid", {31'd0, rsp_valid}, 32'h1);
      chk("nohz_op_a", {16'd0, op_a}, 32'h1234);
      chk("nohz_op_b", {16'd0, op_b}, 32'hABCD);
      step(); step();
      chk("nohz_hold_valid", {31'd0, rsp_valid}, 32'h1);
      chk("nohz_hold_op_a", {16'd0, op_a}, 32'h1234);
      consume();
      chk("nohz_done", {31'd0, rsp_valid}, 32'h0);
      chk("nohz_ready", {31'd0, req_ready}, 32'h1);

      // scoreboard stall then release by writeback
      issue(3'd0, 3'd0, 3'd2, 1'b1);
      chk("sb_busy_set", {24'd0, busy}, 32'h04);
      wait_rsp();
      consume();
      issue(3'd2, 3'd6, 3'd0, 1'b0);
      step(); step(); step();
      chk("sb_stall", {31'd0, rsp_valid}, 32'h0);
      wb(3'd2, 16'h0F0F);
      chk("sb_busy_clr", {24'd0, busy}, 32'h00);
`ifdef GPR_READ_BYPASS_EN
      chk("sb_byp_valid", {31'd0, rsp_valid}, 32'h1);
      chk("sb_byp_op_a", {16'd0, op_a}, 32'h0F0F);
`else
      chk("sb_w_not_yet", {31'd0, rsp_valid}, 32'h0);
      step();
      chk("sb_w1_valid", {31'd0, rsp_valid}, 32'h1);
      chk("sb_w1_op_a", {16'd0, op_a}, 32'h0F0F);
`endif
      chk("sb_op_b", {16'd0, op_b}, 32'h6006);
      consume();

      // src == dst reads the old value without stalling
      issue(3'd1, 3'd1, 3'd1, 1'b1);
      chk("sd_busy", {24'd0, busy}, 32'h02);
      step();
      chk("sd_valid", {31'd0, rsp_valid}, 32'h1);
      chk("sd_op_a", {16'd0, op_a}, 32'h0007);
      consume();
      wb(3'd1, 16'h0007);
      chk("sd_busy_clr", {24'd0, busy}, 32'h00);

      // simultaneous set and clear of the same bit: set wins
      txn(3'd0, 3'd0, 3'd4, 1'b1);
      chk("sc_busy_pre", {24'd0, busy}, 32'h10);
      wb_load = 1; wb_sel = 3'd4; wb_data = 16'h4444;
      issue(3'd0, 3'd7, 3'd4, 1'b1);
      wb_load = 0;
      chk("sc_set_wins", {24'd0, busy}, 32'h10);
      wait_rsp();
      consume();
      wb(3'd4, 16'h4444);
      chk("sc_busy_clr", {24'd0, busy}, 32'h00);

      // reset while stalled with every register busy
      for (int i = 0; i < 8; i++) txn(3'(i), 3'(i), 3'(i), 1'b1);
      chk("mid_busy_ff", {24'd0, busy}, 32'hFF);
      issue(3'd0, 3'd1, 3'd0, 1'b0);
      step(); step();
      chk("mid_stalled", {31'd0, rsp_valid}, 32'h0);
      reset = 0;
      step();
      chk("mid_busy", {24'd0, busy}, 32'h00);
      chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'h0);
      chk("mid_req_ready", {31'd0, req_ready}, 32'h0);
      chk("mid_op_a", {16'd0, op_a}, 32'h0);
      step();
      reset = 1;
      step();
      chk("mid_ready_after", {31'd0, req_ready}, 32'h1);
      issue(3'd3, 3'd5, 3'd0, 1'b0);
      step();
      chk("post_op_a", {16'd0, op_a}, 32'h1234);
      consume();
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
